// File: rtl/uart_command_parser.sv
// uart_command_parser: recognises the CD BA header and a 2-byte command in the
// UART byte stream, publishes the command, then forwards the image payload to
// the decoder through a small first-word-fall-through FIFO.
module uart_command_parser #(
   parameter int FIFO_DEPTH   = 16,
   parameter int IDLE_TIMEOUT = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [2:0] cmd_code,
   output logic       cmd_valid,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   input  logic       stream_done,
   output logic       stream_active,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      HUNT,
      HDR2,
      CMD1,
      CMD2,
      STREAM,
      DRAIN
   } state_t;

   state_t state;
   state_t state_next;

   logic [2:0]    pending;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [TW-1:0] idle_timer;

   logic cmd_byte_ok;
   logic cmd_accept;
   logic fifo_full;
   logic fifo_rd;
   logic fifo_wr_req;
   logic fifo_wr;

   // A command byte is a nibble 1..6 in the upper half and zero in the lower half
   assign cmd_byte_ok = (rx_data[3:0] == 4'h0) &&
                        (rx_data[7:4] >= 4'd1) && (rx_data[7:4] <= 4'd6);

   assign byte_data = mem[rd_ptr];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: header/command decoding, then stream and drain phases
   always_comb begin
      state_next = state;
      case (state)
         HUNT: begin
            if (rx_valid && rx_data == 8'hCD) state_next = HDR2;
         end
         HDR2: begin
            if (rx_valid) begin
               if (rx_data == 8'hBA)      state_next = CMD1;
               else if (rx_data == 8'hCD) state_next = HDR2;
               else                       state_next = HUNT;
            end
         end
         CMD1: begin
            if (rx_valid) state_next = cmd_byte_ok ? CMD2 : HUNT;
         end
         CMD2: begin
            if (rx_valid) state_next = (rx_data == 8'hA0) ? STREAM : HUNT;
         end
         STREAM: begin
            if (stream_done || (!rx_valid && idle_timer == TIMER_LAST)) state_next = DRAIN;
         end
         DRAIN: begin
            if (count == '0) state_next = HUNT;
         end
         default: state_next = HUNT;
      endcase
   end

   // Output and FIFO-control decode; a read frees a slot so write+read when full is legal
   always_comb begin
      stream_active = (state == STREAM) || (state == DRAIN);
      byte_valid    = (count != '0);
      fifo_full     = (count == FULL_COUNT);
      fifo_rd       = byte_valid && byte_ready;
      fifo_wr_req   = (state == STREAM) && rx_valid;
      fifo_wr       = fifo_wr_req && (!fifo_full || fifo_rd);
      cmd_accept    = (state == CMD2) && rx_valid && (rx_data == 8'hA0);
   end

   // Command registers: pending nibble captured in CMD1, published on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= 3'd0;
         cmd_code  <= 3'd0;
         cmd_valid <= 1'b0;
      end else begin
         cmd_valid <= cmd_accept;
         if (state == CMD1 && rx_valid && cmd_byte_ok) pending <= rx_data[6:4];
         if (cmd_accept) cmd_code <= pending;
      end
   end

   // FIFO pointers, occupancy count and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
         if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
         if (fifo_wr && !fifo_rd)      count <= count + (AW + 1)'(1);
         else if (!fifo_wr && fifo_rd) count <= count - (AW + 1)'(1);
         if (fifo_wr_req && !fifo_wr)  overflow <= 1'b1;
      end
   end

   // FIFO storage; contents need no reset because byte_valid gates them
   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr] <= rx_data;
   end

   // Idle timer: runs only in STREAM, cleared by each received byte, saturates
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_timer <= '0;
      end else if (state != STREAM || rx_valid) begin
         idle_timer <= '0;
      end else if (idle_timer != TIMER_LAST) begin
         idle_timer <= idle_timer + TW'(1);
      end
   end

endmodule

// File: tb/tb_uart_command_parser.sv
// tb_uart_command_parser: scenario tasks plus randomized header/command streams
// checked against a pattern-based reference of the parser's byte rules.
module tb_uart_command_parser;

   localparam int DEPTH = 4;
   localparam int TMO   = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] cmd_code;
   logic       cmd_valid;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;
   logic       stream_done;
   logic       stream_active;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] out_q [$];
   logic [2:0] cmd_q [$];

   uart_command_parser #(
      .FIFO_DEPTH  (DEPTH),
      .IDLE_TIMEOUT(TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .cmd_code     (cmd_code),
      .cmd_valid    (cmd_valid),
      .byte_data    (byte_data),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .stream_done  (stream_done),
      .stream_active(stream_active),
      .overflow     (overflow)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Log every command pulse and every accepted payload byte, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid) cmd_q.push_back(cmd_code);
         if (byte_valid && byte_ready) out_q.push_back(byte_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      byte_ready  = 1'b0;
      stream_done = 1'b0;
      tick();
      rst = 1'b0;
      out_q.delete();
      cmd_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_command(input logic [2:0] code);
      send_byte(8'hCD, 0);
      send_byte(8'hBA, 0);
      send_byte({1'b0, code, 4'h0}, 0);
      send_byte(8'hA0, 0);
   endtask

   // Ends any open stream and waits, bounded, for the parser to leave it
   task automatic close_stream();
      int n;
      byte_ready  = 1'b1;
      stream_done = 1'b1;
      tick();
      stream_done = 1'b0;
      n = 0;
      while (stream_active && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (stream_active !== 1'b0) begin
         errors++;
         $display("[TB] FAIL close_stream: stream_active=%b expected 0 after %0d cycles", stream_active, n);
      end
   endtask

   function automatic logic is_cmd_byte(input logic [7:0] b);
      return (b[3:0] == 4'h0) && (b[7:4] >= 4'd1) && (b[7:4] <= 4'd6);
   endfunction

   // Reference: index of the A0 that completes CD BA c0 A0 where the CD was seen
   // while the parser was free (not consumed as a command byte), else -1
   function automatic int find_accept(input logic [7:0] s[$], output logic [2:0] code);
      logic in_cmd1 [64];
      logic in_cmd2 [64];
      logic [7:0] prev;
      code = 3'd0;
      for (int j = 0; j < s.size(); j++) begin
         in_cmd1[j] = (j >= 2) && (s[j-2] == 8'hCD) && (s[j-1] == 8'hBA) &&
                      !in_cmd1[j-2] && !in_cmd2[j-2];
         in_cmd2[j] = (j >= 1) && in_cmd1[j-1] && is_cmd_byte(s[j-1]);
         if (in_cmd2[j] && s[j] == 8'hA0) begin
            prev = s[j-1];
            code = prev[6:4];
            return j;
         end
      end
      return -1;
   endfunction

   function automatic logic [7:0] pick_byte();
      logic [3:0] nib;
      case ($urandom_range(0, 12))
         0, 1, 2: return 8'hCD;
         3, 4:    return 8'hBA;
         5, 6:    return 8'hA0;
         7: begin
            nib = 4'($urandom_range(1, 6));
            return {nib, 4'h0};
         end
         8: begin
            nib = 4'($urandom_range(0, 15));
            return {nib, 4'h0};
         end
         9:       return 8'hA1;
         10:      return 8'h12;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      apply_reset();
      checks++;
      if (cmd_code !== 3'd0) begin errors++; $display("[TB] FAIL reset_cmd_code: got %0d expected 0", cmd_code); end
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
      checks++;
      if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_byte_valid: got %b expected 0", byte_valid); end
      checks++;
      if (stream_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_stream_active: got %b expected 0", stream_active); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_edge_detection();
      logic [7:0] exp [$];
      logic [7:0] got;
      exp = '{8'h01, 8'h02, 8'h03};
      apply_reset();
      byte_ready = 1'b1;
      send_byte(8'hCD, 1);
      send_byte(8'hBA, 1);
      send_byte(8'h10, 1);
      send_byte(8'hA0, 0);
      checks++;
      if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL edge_cmd_valid: got %b expected 1", cmd_valid); end
      checks++;
      if (cmd_code !== 3'd1) begin errors++; $display("[TB] FAIL edge_cmd_code: got %0d expected 1", cmd_code); end
      checks++;
      if (stream_active !== 1'b1) begin errors++; $display("[TB] FAIL edge_stream_active: got %b expected 1", stream_active); end
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL edge_cmd_pulse_width: got %b expected 0", cmd_valid); end
      for (int i = 0; i < 3; i++) send_byte(exp[i], 1);
      repeat (3) tick();
      checks++;
      if (out_q.size() != 3) begin errors++; $display("[TB] FAIL edge_payload_count: got %0d expected 3", out_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin errors++; $display("[TB] FAIL edge_payload[%0d]: got %h expected %h", i, got, exp[i]); end
      end
      close_stream();
   endtask

   task automatic test_resync();
      logic [7:0] seq [$];
      seq = '{8'h55, 8'hCD, 8'hCD, 8'hBA, 8'h40, 8'hA0};
      apply_reset();
      byte_ready = 1'b1;
      foreach (seq[i]) send_byte(seq[i], 1);
      tick();
      checks++;
      if (cmd_q.size() != 1) begin errors++; $display("[TB] FAIL resync_pulses: got %0d expected 1", cmd_q.size()); end
      checks++;
      if (cmd_code !== 3'd4) begin errors++; $display("[TB] FAIL resync_cmd_code: got %0d expected 4", cmd_code); end
      close_stream();
   endtask

   task automatic test_bad_command();
      logic [7:0] seq [$];
      seq = '{8'hCD, 8'hBA, 8'h70, 8'hA0, 8'hCD, 8'hBA, 8'h12, 8'hA0, 8'hCD, 8'hBA, 8'h30, 8'hA1};
      apply_reset();
      byte_ready = 1'b1;
      foreach (seq[i]) send_byte(seq[i], 0);
      tick();
      checks++;
      if (cmd_q.size() != 0) begin errors++; $display("[TB] FAIL bad_cmd_pulses: got %0d expected 0", cmd_q.size()); end
      checks++;
      if (stream_active !== 1'b0) begin errors++; $display("[TB] FAIL bad_cmd_stream_active: got %b expected 0", stream_active); end
      checks++;
      if (cmd_code !== 3'd0) begin errors++; $display("[TB] FAIL bad_cmd_code_held: got %0d expected 0", cmd_code); end
      send_command(3'd6);
      tick();
      checks++;
      if (cmd_q.size() != 1) begin errors++; $display("[TB] FAIL bad_cmd_recover_pulses: got %0d expected 1", cmd_q.size()); end
      checks++;
      if (cmd_code !== 3'd6) begin errors++; $display("[TB] FAIL bad_cmd_recover_code: got %0d expected 6", cmd_code); end
      close_stream();
   endtask

   task automatic test_overflow();
      logic [7:0] got;
      apply_reset();
      send_command(3'd2);
      for (int i = 0; i < 6; i++) send_byte(8'(i), 0);
      tick();
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_flag: got %b expected 1", overflow); end
      checks++;
      if (byte_valid !== 1'b1 || byte_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL overflow_head: got valid=%b data=%h expected valid=1 data=00", byte_valid, byte_data);
      end
      byte_ready = 1'b1;
      repeat (8) tick();
      checks++;
      if (out_q.size() != DEPTH) begin errors++; $display("[TB] FAIL overflow_count: got %0d expected %0d", out_q.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 8'hxx;
         checks++;
         if (got !== 8'(i)) begin errors++; $display("[TB] FAIL overflow_data[%0d]: got %h expected %h", i, got, 8'(i)); end
      end
      close_stream();
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_drain();
      logic [7:0] exp [$];
      logic [7:0] got;
      int n;
      exp = '{8'hAA, 8'hBB, 8'hCC};
      apply_reset();
      send_command(3'd3);
      foreach (exp[i]) send_byte(exp[i], 0);
      stream_done = 1'b1;
      tick();
      stream_done = 1'b0;
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      stream_done = 1'b1;
      tick();
      stream_done = 1'b0;
      repeat (4) tick();
      checks++;
      if (stream_active !== 1'b1) begin errors++; $display("[TB] FAIL drain_hold_active: got %b expected 1", stream_active); end
      byte_ready = 1'b1;
      n = 0;
      while (stream_active && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (stream_active !== 1'b0) begin errors++; $display("[TB] FAIL drain_release: got %b expected 0", stream_active); end
      checks++;
      if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", byte_valid); end
      checks++;
      if (out_q.size() != 3) begin errors++; $display("[TB] FAIL drain_count: got %0d expected 3", out_q.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_timeout();
      int n;
      apply_reset();
      send_command(3'd1);
      byte_ready = 1'b1;
      send_byte(8'h5A, 0);
      n = 0;
      while (stream_active && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (stream_active !== 1'b0) begin errors++; $display("[TB] FAIL timeout_close: got %b expected 0", stream_active); end
      checks++;
      if (n < TMO - 1 || n > TMO + 3) begin
         errors++;
         $display("[TB] FAIL timeout_cycles: got %0d expected %0d..%0d", n, TMO - 1, TMO + 3);
      end
      checks++;
      if (out_q.size() != 1 || out_q[0] !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL timeout_payload: got %0d bytes expected 1 byte 5a", out_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      send_command(3'd4);
      for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 0);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre_overflow: got %b expected 1", overflow); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_byte_valid: got %b expected 0", byte_valid); end
      checks++;
      if (stream_active !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stream_active: got %b expected 0", stream_active); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midreset_overflow: got %b expected 0", overflow); end
      checks++;
      if (cmd_code !== 3'd0) begin errors++; $display("[TB] FAIL midreset_cmd_code: got %0d expected 0", cmd_code); end
      out_q.delete();
      cmd_q.delete();
      byte_ready = 1'b1;
      send_command(3'd5);
      tick();
      checks++;
      if (cmd_q.size() != 1 || cmd_code !== 3'd5) begin
         errors++;
         $display("[TB] FAIL midreset_new_cmd: got %0d pulses code %0d expected 1 pulse code 5", cmd_q.size(), cmd_code);
      end
      checks++;
      if (out_q.size() != 0) begin errors++; $display("[TB] FAIL midreset_stale_bytes: got %0d expected 0", out_q.size()); end
      close_stream();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [$];
      logic [7:0] got;
      int n;
      exp = '{8'hCD, 8'hBA, 8'h10, 8'hA0};
      for (int i = 0; i < 4; i++) exp.push_back(8'($urandom));
      apply_reset();
      byte_ready = 1'b1;
      send_command(3'd6);
      for (int i = 0; i < 7; i++) send_byte(exp[i], 0);
      rx_data     = exp[7];
      rx_valid    = 1'b1;
      stream_done = 1'b1;
      tick();
      rx_valid    = 1'b0;
      stream_done = 1'b0;
      n = 0;
      while (stream_active && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (stream_active !== 1'b0) begin errors++; $display("[TB] FAIL b2b_close: got %b expected 0", stream_active); end
      checks++;
      if (cmd_q.size() != 1 || cmd_code !== 3'd6) begin
         errors++;
         $display("[TB] FAIL b2b_single_cmd: got %0d pulses code %0d expected 1 pulse code 6", cmd_q.size(), cmd_code);
      end
      checks++;
      if (out_q.size() != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", out_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < out_q.size()) ? out_q[i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_random_commands();
      logic [7:0] seq [$];
      logic [7:0] got;
      logic [2:0] code;
      int acc;
      int exp_n;
      for (int t = 0; t < 30; t++) begin
         seq.delete();
         for (int i = 0; i < $urandom_range(3, 10); i++) seq.push_back(pick_byte());
         if ($urandom_range(0, 1) == 1) begin
            seq.push_back(8'hCD);
            seq.push_back(8'hBA);
            seq.push_back({1'b0, 3'($urandom_range(1, 6)), 4'h0});
            seq.push_back(8'hA0);
         end
         for (int i = 0; i < $urandom_range(0, 4); i++) seq.push_back(8'($urandom));
         acc = find_accept(seq, code);
         apply_reset();
         byte_ready = 1'b1;
         foreach (seq[i]) send_byte(seq[i], $urandom_range(0, 2));
         close_stream();
         checks++;
         if (acc < 0) begin
            if (cmd_q.size() != 0) begin
               errors++;
               $display("[TB] FAIL rand%0d_no_cmd: got %0d pulses expected 0", t, cmd_q.size());
            end
         end else if (cmd_q.size() != 1 || cmd_q[0] !== code) begin
            errors++;
            $display("[TB] FAIL rand%0d_cmd: got %0d pulses first %0d expected 1 pulse code %0d",
                     t, cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 3'd0, code);
         end
         exp_n = (acc < 0) ? 0 : seq.size() - acc - 1;
         checks++;
         if (out_q.size() != exp_n) begin
            errors++;
            $display("[TB] FAIL rand%0d_payload_count: got %0d expected %0d", t, out_q.size(), exp_n);
         end
         for (int i = 0; i < exp_n; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++;
            if (got !== seq[acc + 1 + i]) begin
               errors++;
               $display("[TB] FAIL rand%0d_payload[%0d]: got %h expected %h", t, i, got, seq[acc + 1 + i]);
            end
         end
      end
   endtask

   // Scenario sequence and summary
   initial begin
      test_reset();
      test_edge_detection();
      test_resync();
      test_bad_command();
      test_overflow();
      test_drain();
      test_timeout();
      test_reset_midstream();
      test_back_to_back();
      test_random_commands();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
